// File: rtl/sequence_generator_1011.sv
// rtl/sequence_generator_1011.sv - MSB-first serial word transmitter with built-in overlapping Moore 1011 golden detector
module sequence_generator_1011 #(
  parameter int                     DATA_WIDTH    = 16,
  parameter int                     PATTERN_WIDTH = 4,
  parameter logic [PATTERN_WIDTH-1:0] PATTERN     = 4'b1011,
  parameter int                     COUNT_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [DATA_WIDTH-1:0]  load_data,
  input  logic                   clear_count,
  output logic                   sequence_out,
  output logic                   sequence_valid,
  output logic                   done,
  output logic                   expected_detect,
  output logic [COUNT_WIDTH-1:0] pattern_count
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int FW = $clog2(PATTERN_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   state;
  logic [DATA_WIDTH-1:0]    shreg;
  logic [CW-1:0]            bit_cnt;
  logic [PATTERN_WIDTH-1:0] hist;
  logic [FW-1:0]            fill;

  // bit_cnt indexes the bit currently on the line; load_ready is pre-computed for the next cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      shreg          <= '0;
      bit_cnt        <= '0;
      sequence_out   <= 1'b0;
      sequence_valid <= 1'b0;
      done           <= 1'b0;
      load_ready     <= 1'b1;
    end else begin
      done <= 1'b0;
      if (load_valid && load_ready) begin
        state          <= SHIFT;
        shreg          <= load_data;
        bit_cnt        <= CW'(DATA_WIDTH - 1);
        sequence_out   <= load_data[DATA_WIDTH-1];
        sequence_valid <= 1'b1;
        load_ready     <= 1'b0;
      end else if (state == SHIFT && bit_cnt != '0) begin
        bit_cnt      <= bit_cnt - CW'(1);
        sequence_out <= shreg[bit_cnt - CW'(1)];
        done         <= (bit_cnt == CW'(1));
        load_ready   <= (bit_cnt == CW'(1));
      end else begin
        state          <= IDLE;
        sequence_out   <= 1'b0;
        sequence_valid <= 1'b0;
        load_ready     <= 1'b1;
      end
    end
  end

  // Golden model watches the physical line, idle zeros included
  always_ff @(posedge clock) begin
    if (reset) begin
      hist          <= '0;
      fill          <= '0;
      pattern_count <= '0;
    end else begin
      hist <= (hist << 1) | PATTERN_WIDTH'(sequence_out);
      if (fill != FW'(PATTERN_WIDTH))
        fill <= fill + FW'(1);
      if (clear_count)
        pattern_count <= '0;
      else if (expected_detect && pattern_count != '1)
        pattern_count <= pattern_count + COUNT_WIDTH'(1);
    end
  end

  assign expected_detect = (fill == FW'(PATTERN_WIDTH)) && (hist == PATTERN);

endmodule

// File: tb/tb_sequence_generator_1011.sv
// tb/tb_sequence_generator_1011.sv - scoreboard bench: bit-queue reference model vs two DUT instances (8-bit and 2-bit counters)
module tb_sequence_generator_1011;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        clear_count = 1'b0;
  logic        load_ready, sequence_out, sequence_valid, done, expected_detect;
  logic [7:0]  pattern_count;
  logic        load_ready2, sequence_out2, sequence_valid2, done2, expected_detect2;
  logic [1:0]  pattern_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  sequence_generator_1011 dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .clear_count(clear_count), .sequence_out(sequence_out),
    .sequence_valid(sequence_valid), .done(done), .expected_detect(expected_detect),
    .pattern_count(pattern_count)
  );

  sequence_generator_1011 #(.COUNT_WIDTH(2)) dut2 (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready2),
    .load_data(load_data), .clear_count(clear_count), .sequence_out(sequence_out2),
    .sequence_valid(sequence_valid2), .done(done2), .expected_detect(expected_detect2),
    .pattern_count(pattern_count2)
  );

  typedef struct {
    bit out; bit valid; bit dn; bit ready; bit det; int cnt; int cnt2;
  } exp_t;

  typedef struct { bit b; bit last; } txbit_t;

  exp_t   exp_q[$];
  txbit_t tx_q[$];
  bit     line_q[$];

  // Reference state describing the cycle currently on the DUT outputs
  bit m_out, m_valid, m_done, m_det;
  int m_cnt, m_cnt2;

  task automatic chk(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic step(bit rst, bit lv, logic [15:0] d, bit clr);
    exp_t e;
    txbit_t t;
    @(negedge clock);
    reset = rst; load_valid = lv; load_data = d; clear_count = clr;
    if (rst) begin
      tx_q.delete(); line_q.delete();
      m_out = 0; m_valid = 0; m_done = 0; m_det = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      line_q.push_back(m_out);
      if (line_q.size() > 4) void'(line_q.pop_front());
      if (clr) begin
        m_cnt = 0; m_cnt2 = 0;
      end else if (m_det) begin
        m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
      end
      if (lv && tx_q.size() == 0)
        for (int i = 15; i >= 0; i--) tx_q.push_back('{b: d[i], last: (i == 0)});
      if (tx_q.size() != 0) begin
        t = tx_q.pop_front();
        m_out = t.b; m_valid = 1; m_done = t.last;
      end else begin
        m_out = 0; m_valid = 0; m_done = 0;
      end
      m_det = (line_q.size() == 4) && line_q[0] && !line_q[1] && line_q[2] && line_q[3];
    end
    e.out = m_out; e.valid = m_valid; e.dn = m_done; e.det = m_det;
    e.ready = (tx_q.size() == 0); e.cnt = m_cnt; e.cnt2 = m_cnt2;
    exp_q.push_back(e);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 16'h0, 0);
  endtask

  // Holds load_valid until the reference model says the word was taken
  task automatic send(logic [15:0] d);
    bit acc;
    for (int k = 0; k < 40; k++) begin
      acc = (tx_q.size() == 0);
      step(0, 1, d, 0);
      if (acc) break;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sequence_out",    sequence_out,    e.out);
        chk("sequence_valid",  sequence_valid,  e.valid);
        chk("done",            done,            e.dn);
        chk("load_ready",      load_ready,      e.ready);
        chk("expected_detect", expected_detect, e.det);
        chk("pattern_count",   pattern_count,   e.cnt);
        chk("pattern_count_w2", pattern_count2, e.cnt2);
      end
    end
  end

  initial begin : stimulus
    step(1, 0, 16'h0, 0);
    step(1, 1, 16'hFFFF, 1);
    send(16'hB000); idle(20);
    send(16'hB600); idle(20);
    send(16'h000B); send(16'h6000); idle(20);
    send(16'h0001); idle(16); send(16'hC000); idle(20);
    send(16'hFFFF); idle(2); step(1, 1, 16'hAAAA, 0); idle(3);
    send(16'hB000); idle(20);
    send(16'hBBBB); send(16'hBBBB); send(16'hBBBB); send(16'hBBBB); idle(6);
    step(0, 0, 16'h0, 1); idle(3);
    send(16'hB000); idle(5); step(0, 0, 16'h0, 1); idle(5);
    for (int k = 0; k < 1500; k++) begin
      logic [15:0] d;
      d = (k % 7 == 0) ? 16'hB6DB : 16'($urandom);
      step($urandom_range(0, 400) == 0, $urandom_range(0, 3) != 0, d,
           $urandom_range(0, 30) == 0);
    end
    idle(20);
    @(posedge clock);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
